// File: rtl/pattern_sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_sweeper_pkg
// Description : Shared types and sizing constants for the pattern sweeper:
//               FSM state encoding, vector count/width, result width and
//               hold-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_sweeper_pkg;

    localparam int VEC_COUNT = 16;   // number of input vectors in one sweep
    localparam int VEC_W     = 4;    // width of the vector index / stimulus
    localparam int RES_W     = 3;    // width of one captured result {g,f,e}
    localparam int CNT_W     = 16;   // width of the hold counter

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : pattern_sweeper_pkg
`default_nettype wire

// File: rtl/pattern_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module      : pattern_sweeper_if
// Description : Control, stimulus/response and result-readback signals of
//               the pattern sweeper. The slave modport is the sweeper side,
//               the master modport is the controlling/environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pattern_sweeper_if;
    import pattern_sweeper_pkg::*;

    // sweep control
    logic               start;
    logic               continuous;
    logic               abort;
    // stimulus to the logic block under test
    logic               a;
    logic               b;
    logic               c;
    logic               d;
    // responses from the logic block under test
    logic               e_in;
    logic               f_in;
    logic               g_in;
    // status
    logic               busy;
    logic               done;
    logic [VEC_W-1:0]   vec_idx;
    // result-memory readback
    logic [VEC_W-1:0]   rd_addr;
    logic [RES_W-1:0]   rd_data;

    modport slave (
        input  start, continuous, abort, e_in, f_in, g_in, rd_addr,
        output a, b, c, d, busy, done, vec_idx, rd_data
    );

    modport master (
        output start, continuous, abort, e_in, f_in, g_in, rd_addr,
        input  a, b, c, d, busy, done, vec_idx, rd_data
    );

endinterface : pattern_sweeper_if
`default_nettype wire

// File: rtl/pattern_sweeper_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : hold_timer
// Description : Loadable down-counter with a zero flag. Load has priority
//               over decrement; the count saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_timer
    import pattern_sweeper_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] load_val_i,
    input  wire logic             dec_i,
    output logic                  zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // next count: reload, step down, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : hold_timer
`default_nettype wire

// File: rtl/pattern_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : pattern_sweeper
// Description : Walks a 4-input logic block through all 16 input vectors,
//               holds each for HOLD_CYCLES cycles, samples the 3 returned
//               bits into a 16x3 result memory, and supports single-shot,
//               continuous and aborted sweeps plus registered readback.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_sweeper
    import pattern_sweeper_pkg::*;
#(
    parameter int HOLD_CYCLES = 50   // legal range 1..65535
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pattern_sweeper_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(VEC_COUNT - 1);

    state_t             state_q;
    state_t             state_d;
    logic [VEC_W-1:0]   vec_q;
    logic [VEC_W-1:0]   vec_d;
    logic               done_q;
    logic               done_d;
    logic               timer_load;
    logic               timer_dec;
    logic               timer_zero;
    logic               wr_en;
    logic               busy_w;

    logic [RES_W-1:0]   mem_q [VEC_COUNT];
    logic [RES_W-1:0]   rd_data_q;

    hold_timer #(
        .WIDTH      (CNT_W)
    ) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (HOLD_RELOAD),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    // next state, vector index, timer control, memory write and done pulse
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_DRIVE;
                    vec_d      = '0;
                    timer_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (timer_zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                wr_en = 1'b1;
                if (vec_q != LAST_VEC) begin
                    vec_d      = vec_q + VEC_W'(1);
                    timer_load = 1'b1;
                    state_d    = ST_DRIVE;
                end else begin
                    // done is registered so that in continuous mode it lands
                    // on the first DRIVE cycle of the following sweep
                    vec_d  = '0;
                    done_d = 1'b1;
                    if (bus.continuous) begin
                        timer_load = 1'b1;
                        state_d    = ST_DRIVE;
                    end else begin
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // abort overrides everything, including start and sweep completion
        if (bus.abort) begin
            state_d    = ST_IDLE;
            vec_d      = '0;
            done_d     = 1'b0;
            timer_load = 1'b0;
            timer_dec  = 1'b0;
            wr_en      = 1'b0;
        end
    end

    // FSM state, vector index and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            done_q  <= done_d;
        end
    end

    // result memory: capture {g,f,e} for the current vector in SAMPLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VEC_COUNT; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[vec_q] <= {bus.g_in, bus.f_in, bus.e_in};
        end
    end

    // registered readback; same-cycle write is not visible (returns old value)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[bus.rd_addr];
        end
    end

    assign busy_w      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign bus.busy    = busy_w;
    assign bus.done    = done_q;
    assign bus.vec_idx = vec_q;
    assign bus.a       = busy_w & vec_q[0];
    assign bus.b       = busy_w & vec_q[1];
    assign bus.c       = busy_w & vec_q[2];
    assign bus.d       = busy_w & vec_q[3];
    assign bus.rd_data = rd_data_q;

endmodule : pattern_sweeper
`default_nettype wire

// File: tb/tb_pattern_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_sweeper
// Description : Directed self-checking bench for pattern_sweeper. One DUT
//               with HOLD_CYCLES=4 and one with HOLD_CYCLES=1, each looped
//               back through a small combinational block under test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_sweeper;
    import pattern_sweeper_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic inv4;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [2:0] exp_mem [16];

    pattern_sweeper_if if4 ();
    pattern_sweeper_if if1 ();

    always #5 clk = ~clk;

    // block under test: e = OR (optionally inverted), f = parity, g = c&d
    assign if4.e_in = (if4.a | if4.b | if4.c | if4.d) ^ inv4;
    assign if4.f_in = if4.a ^ if4.b ^ if4.c ^ if4.d;
    assign if4.g_in = if4.d & if4.c;
    assign if1.e_in = if1.a | if1.b | if1.c | if1.d;
    assign if1.f_in = if1.a ^ if1.b ^ if1.c ^ if1.d;
    assign if1.g_in = if1.d & if1.c;

    pattern_sweeper #(.HOLD_CYCLES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    pattern_sweeper #(.HOLD_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // expected memory content for vector v through the loopback block
    function automatic logic [2:0] loop_val(input int v, input logic inv);
        logic [3:0] x;
        x = v[3:0];
        return {x[3] & x[2], ^x, (x != 4'd0) ^ inv};
    endfunction

    task automatic read4(input int addr, output logic [2:0] data);
        @(negedge clk);
        if4.rd_addr = addr[3:0];
        @(negedge clk);
        data = if4.rd_data;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({if4.busy, if4.done, if4.a, if4.b, if4.c, if4.d} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl4: got %b expected 000000", {if4.busy, if4.done, if4.a, if4.b, if4.c, if4.d});
        end
        n_tests++;
        if ({if4.vec_idx, if4.rd_data, if1.vec_idx, if1.busy, if1.done} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_misc: got %b expected 0", {if4.vec_idx, if4.rd_data, if1.vec_idx, if1.busy, if1.done});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (if4.busy !== 1'b0 || if4.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy %b done %b expected 0 0", if4.busy, if4.done);
        end
    endtask

    task automatic test_sweep();
        int busy_cnt = 0;
        logic got = 1'b0;
        logic [2:0] rd;
        @(negedge clk);
        if4.start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if4.start = 1'b0;
                n_tests++;
                if (if4.busy !== 1'b1 || if4.vec_idx !== 4'd0) begin
                    n_fail++;
                    $display("FAIL sweep_first_drive: busy %b vec %0d expected 1 0", if4.busy, if4.vec_idx);
                end
            end
            if (k == 80) begin
                n_tests++;
                if (if4.vec_idx !== 4'd15 || {if4.d, if4.c, if4.b, if4.a} !== 4'hF) begin
                    n_fail++;
                    $display("FAIL sweep_last_vec: vec %0d expected 15", if4.vec_idx);
                end
            end
            if (if4.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (if4.busy === 1'b1) busy_cnt++;
        end
        n_tests++;
        if (!got || busy_cnt != 80) begin
            n_fail++;
            $display("FAIL sweep_length: got done=%b after %0d busy cycles expected 1 after 80", got, busy_cnt);
        end
        @(negedge clk);
        n_tests++;
        if (if4.done !== 1'b0 || if4.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_done_pulse: done %b busy %b expected 0 0", if4.done, if4.busy);
        end
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = loop_val(i, 1'b0);
            read4(i, rd);
            n_tests++;
            if (rd !== exp_mem[i]) begin
                n_fail++;
                $display("FAIL sweep_mem[%0d]: got %b expected %b", i, rd, exp_mem[i]);
            end
        end
    endtask

    task automatic test_hold1();
        @(negedge clk);
        if1.start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) if1.start = 1'b0;
            if (k <= 32) begin
                n_tests++;
                if (if1.vec_idx !== 4'((k - 1) / 2) || {if1.d, if1.c, if1.b, if1.a} !== if1.vec_idx || if1.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL hold1_step k=%0d: vec %0d dcba %b busy %b expected vec %0d busy 1",
                             k, if1.vec_idx, {if1.d, if1.c, if1.b, if1.a}, if1.busy, (k - 1) / 2);
                end
            end else begin
                n_tests++;
                if (if1.done !== 1'b1 || {if1.d, if1.c, if1.b, if1.a} !== 4'h0) begin
                    n_fail++;
                    $display("FAIL hold1_done: done %b dcba %b expected 1 0000", if1.done, {if1.d, if1.c, if1.b, if1.a});
                end
                break;
            end
        end
    endtask

    task automatic test_abort();
        logic seen_done = 1'b0;
        logic [2:0] rd;
        // abort mid-DRIVE of vector 7 with the response inverted
        inv4 = 1'b1;
        @(negedge clk);
        if4.start = 1'b1;
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            if (k == 1) if4.start = 1'b0;
            if (k == 37) begin
                n_tests++;
                if (if4.vec_idx !== 4'd7 || if4.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort_pre: vec %0d busy %b expected 7 1", if4.vec_idx, if4.busy);
                end
                if4.abort = 1'b1;
            end
            if (k == 38) begin
                if4.abort = 1'b0;
                n_tests++;
                if ({if4.busy, if4.done, if4.d, if4.c, if4.b, if4.a} !== 6'b0) begin
                    n_fail++;
                    $display("FAIL abort_idle: busy,done,dcba %b expected 000000", {if4.busy, if4.done, if4.d, if4.c, if4.b, if4.a});
                end
            end
        end
        repeat (10) begin
            @(negedge clk);
            if (if4.done === 1'b1 || if4.busy === 1'b1) seen_done = 1'b1;
        end
        n_tests++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL abort_quiet: got activity after abort expected none");
        end
        for (int i = 0; i < 7; i++) exp_mem[i] = loop_val(i, 1'b1);
        // abort exactly in the SAMPLE cycle of vector 2: that write must not land
        inv4 = 1'b0;
        @(negedge clk);
        if4.start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) if4.start = 1'b0;
            if (k == 15) begin
                n_tests++;
                if (if4.vec_idx !== 4'd2) begin
                    n_fail++;
                    $display("FAIL abort_sample_pre: vec %0d expected 2", if4.vec_idx);
                end
                if4.abort = 1'b1;
            end
            if (k == 16) begin
                if4.abort = 1'b0;
                n_tests++;
                if (if4.busy !== 1'b0 || if4.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_sample_idle: busy %b done %b expected 0 0", if4.busy, if4.done);
                end
            end
        end
        exp_mem[0] = loop_val(0, 1'b0);
        exp_mem[1] = loop_val(1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            read4(i, rd);
            n_tests++;
            if (rd !== exp_mem[i]) begin
                n_fail++;
                $display("FAIL abort_mem[%0d]: got %b expected %b", i, rd, exp_mem[i]);
            end
        end
    endtask

    task automatic test_continuous();
        int np = 0;
        int tk [3];
        logic busy_at_first = 1'b0;
        logic [2:0] rd;
        tk[0] = 0; tk[1] = 0; tk[2] = 0;
        if4.continuous = 1'b1;
        @(negedge clk);
        if4.start = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) if4.start = 1'b0;
            if (if4.done === 1'b1) begin
                tk[np] = k;
                if (np == 0) busy_at_first = if4.busy;
                np++;
                if (np == 2) if4.continuous = 1'b0;
                if (np == 3) break;
            end
        end
        n_tests++;
        if (np != 3 || tk[0] != 81 || tk[1] - tk[0] != 80 || tk[2] - tk[1] != 80) begin
            n_fail++;
            $display("FAIL cont_pulses: got %0d pulses at %0d,%0d,%0d expected 3 at 81,161,241", np, tk[0], tk[1], tk[2]);
        end
        n_tests++;
        if (busy_at_first !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_overlap: busy %b at first done expected 1", busy_at_first);
        end
        @(negedge clk);
        n_tests++;
        if (if4.busy !== 1'b0 || if4.done !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_stop: busy %b done %b expected 0 0", if4.busy, if4.done);
        end
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = loop_val(i, 1'b0);
            read4(i, rd);
            n_tests++;
            if (rd !== exp_mem[i]) begin
                n_fail++;
                $display("FAIL cont_mem[%0d]: got %b expected %b", i, rd, exp_mem[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int busy_cnt = 0;
        logic got = 1'b0;
        logic woke = 1'b0;
        @(negedge clk);
        if4.start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1 || k == 21 || k == 51) if4.start = 1'b0;
            if (k == 20 || k == 50) if4.start = 1'b1;
            if (k == 21) begin
                n_tests++;
                if (if4.vec_idx !== 4'd4) begin
                    n_fail++;
                    $display("FAIL busy_start_vec: vec %0d expected 4", if4.vec_idx);
                end
            end
            if (if4.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (if4.busy === 1'b1) busy_cnt++;
        end
        n_tests++;
        if (!got || busy_cnt != 80) begin
            n_fail++;
            $display("FAIL busy_start_len: done=%b after %0d busy cycles expected 1 after 80", got, busy_cnt);
        end
        @(negedge clk);
        if4.start = 1'b1;
        if4.abort = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        if4.abort = 1'b0;
        if (if4.busy !== 1'b0) woke = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (if4.busy !== 1'b0 || if4.done !== 1'b0) woke = 1'b1;
        end
        n_tests++;
        if (woke) begin
            n_fail++;
            $display("FAIL start_abort_idle: got busy/done activity expected IDLE");
        end
    endtask

    task automatic test_reset_midsweep();
        int busy_cnt = 0;
        logic got = 1'b0;
        logic [2:0] rd;
        if4.rd_addr = 4'd5;
        @(negedge clk);
        if4.start = 1'b1;
        for (int k = 1; k <= 47; k++) begin
            @(negedge clk);
            if (k == 1) if4.start = 1'b0;
        end
        n_tests++;
        if (if4.vec_idx !== 4'd9 || if4.rd_data !== 3'b001) begin
            n_fail++;
            $display("FAIL rst_pre: vec %0d rd %b expected 9 001", if4.vec_idx, if4.rd_data);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({if4.busy, if4.done, if4.d, if4.c, if4.b, if4.a, if4.vec_idx, if4.rd_data} !== 13'b0) begin
            n_fail++;
            $display("FAIL rst_async: outputs %b expected 0",
                     {if4.busy, if4.done, if4.d, if4.c, if4.b, if4.a, if4.vec_idx, if4.rd_data});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            read4(i, rd);
            n_tests++;
            if (rd !== 3'b000) begin
                n_fail++;
                $display("FAIL rst_mem[%0d]: got %b expected 000", i, rd);
            end
        end
        // start presented on the first edge after reset release
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        if4.start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if4.start = 1'b0;
                n_tests++;
                if (if4.busy !== 1'b1 || if4.vec_idx !== 4'd0) begin
                    n_fail++;
                    $display("FAIL rst_first_start: busy %b vec %0d expected 1 0", if4.busy, if4.vec_idx);
                end
            end
            if (if4.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (if4.busy === 1'b1) busy_cnt++;
        end
        n_tests++;
        if (!got || busy_cnt != 80) begin
            n_fail++;
            $display("FAIL rst_resweep: done=%b after %0d busy cycles expected 1 after 80", got, busy_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            read4(i, rd);
            n_tests++;
            if (rd !== loop_val(i, 1'b0)) begin
                n_fail++;
                $display("FAIL rst_resweep_mem[%0d]: got %b expected %b", i, rd, loop_val(i, 1'b0));
            end
        end
    endtask

    initial begin
        rst_n          = 1'b1;
        inv4           = 1'b0;
        if4.start      = 1'b0;
        if4.continuous = 1'b0;
        if4.abort      = 1'b0;
        if4.rd_addr    = 4'd0;
        if1.start      = 1'b0;
        if1.continuous = 1'b0;
        if1.abort      = 1'b0;
        if1.rd_addr    = 4'd0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 3'b000;

        test_reset();
        test_sweep();
        test_hold1();
        test_abort();
        test_continuous();
        test_start_ignored();
        test_reset_midsweep();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule : tb_pattern_sweeper
`default_nettype wire
